gmii_rx_logger: RTL and testbench

Receive-side GMII frame logger for the 1000BASE-T tap: watches one PHY's GMII receive stream in the PLL'd rx clock domain, strips preamble/SFD, and pushes frame bytes plus a per-frame end marker into the log data FIFO. It also pushes one 64-bit metadata word per logged frame into the log meta FIFO: timestamp, status flags, byte length. It is the write-side producer for the data/meta FIFO pair that the USB-side log reader drains.

---
 rtl/gmii_rx_logger.sv | 202 ++++++++++++++++++++
 tb/tb_gmii_rx_logger.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_logger.sv
// GMII receive-side frame logger: strips preamble/SFD, streams frame bytes to the
// log data FIFO and emits one {timestamp, flags, length} word per frame to the meta FIFO.
module gmii_rx_logger #(
  parameter int MAX_LEN = 2048,
  parameter int MIN_LEN = 64
) (
  input  logic        rx_clk,
  input  logic        reset,
  input  logic        rx_dv,
  input  logic [7:0]  rxd,
  input  logic        rx_er,
  input  logic [31:0] timestamp,
  input  logic        data_almost_full,
  input  logic        meta_full,
  output logic        log_en,
  output logic [7:0]  log_d,
  output logic        log_frame_end,
  output logic        meta_en,
  output logic [63:0] meta_d,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count
);

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
  localparam logic [7:0]  PRE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE  = 8'hD5;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DISCARD,
    FINISH
  } state_t;

  state_t      state;
  state_t      state_n;
  logic        rx_dv_prev;
  logic        rise;

  logic        wr;
  logic        wr_end;
  logic        start;
  logic        take;
  logic        set_trunc;
  logic        set_er;
  logic        fin;
  logic        drop;

  logic [7:0]  hold_p0;
  logic        vld_p0;
  logic [15:0] length;
  logic [31:0] crc;
  logic [31:0] ts_lat;
  logic        trunc_flag;
  logic        er_flag;
  logic        crc_ok;
  logic        runt;
  logic [15:0] flags;

  // Reflected CRC-32 over one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign rise = rx_dv & ~rx_dv_prev;

  // The register runs LSB-first, so the MSB-first residue constant is matched bit-reversed.
  assign crc_ok = (bit_rev32(crc) == 32'hC704DD7B);
  assign runt   = (length < MIN_LEN_W);
  assign flags  = {12'h000, runt, trunc_flag, er_flag, crc_ok};

  always_comb begin
    state_n   = state;
    wr        = 1'b0;
    wr_end    = 1'b0;
    start     = 1'b0;
    take      = 1'b0;
    set_trunc = 1'b0;
    set_er    = 1'b0;
    fin       = 1'b0;
    drop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) state_n = PREAMBLE;
      end
      PREAMBLE: begin
        if (!rx_dv) begin
          state_n = IDLE;
        end else if (rxd == SFD_BYTE) begin
          if (data_almost_full || meta_full) begin
            state_n = DISCARD;
            drop    = 1'b1;
          end else begin
            state_n = DATA;
            start   = 1'b1;
          end
        end else if (rxd != PRE_BYTE) begin
          state_n = IDLE;
        end
      end
      DATA: begin
        set_er = rx_er;
        if (rx_dv) begin
          take = 1'b1;
          if (vld_p0 && !trunc_flag) begin
            wr = 1'b1;
            if (length == MAX_LEN_W) begin
              wr_end    = 1'b1;
              set_trunc = 1'b1;
            end
          end
        end else begin
          if (vld_p0 && !trunc_flag) begin
            wr     = 1'b1;
            wr_end = 1'b1;
          end
          state_n = FINISH;
        end
      end
      DISCARD: begin
        if (!rx_dv) state_n = IDLE;
      end
      FINISH: begin
        fin     = 1'b1;
        state_n = rise ? PREAMBLE : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (reset) begin
      state         <= IDLE;
      rx_dv_prev    <= 1'b1;
      vld_p0        <= 1'b0;
      trunc_flag    <= 1'b0;
      er_flag       <= 1'b0;
      log_en        <= 1'b0;
      log_d         <= 8'h00;
      log_frame_end <= 1'b0;
      meta_en       <= 1'b0;
      meta_d        <= 64'h0;
      frame_count   <= 16'h0000;
      drop_count    <= 16'h0000;
    end else begin
      state      <= state_n;
      rx_dv_prev <= rx_dv;
      if (start) begin
        vld_p0     <= 1'b0;
        trunc_flag <= 1'b0;
        er_flag    <= 1'b0;
      end else begin
        if (take)      vld_p0     <= 1'b1;
        if (set_trunc) trunc_flag <= 1'b1;
        if (set_er)    er_flag    <= 1'b1;
      end
      // Output stage: held byte leaves one cycle after it was captured.
      log_en        <= wr;
      log_frame_end <= wr_end;
      if (wr) log_d <= hold_p0;
      meta_en <= fin;
      if (fin) begin
        meta_d      <= {ts_lat, flags, length};
        frame_count <= frame_count + 16'd1;
      end
      if (drop) drop_count <= drop_count + 16'd1;
    end
  end

  // Capture stage: byte hold, running length and CRC.
  always_ff @(posedge rx_clk) begin
    if (start) begin
      length <= 16'h0000;
      crc    <= 32'hFFFFFFFF;
      ts_lat <= timestamp;
    end else if (take) begin
      hold_p0 <= rxd;
      length  <= sat_inc16(length);
      crc     <= crc32_byte(crc, rxd);
    end
  end

endmodule

// File: tb/tb_gmii_rx_logger.sv
// Directed bench for gmii_rx_logger: good/bad FCS, rx_er, drops, truncation,
// zero-byte frame, minimum gap and mid-frame reset.
module tb_gmii_rx_logger;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_dv;
  logic [7:0]  rxd;
  logic        rx_er;
  logic [31:0] timestamp;
  logic        data_almost_full;
  logic        meta_full;
  logic        log_en;
  logic [7:0]  log_d;
  logic        log_frame_end;
  logic        meta_en;
  logic [63:0] meta_d;
  logic [15:0] frame_count;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  gmii_rx_logger #(.MAX_LEN(128), .MIN_LEN(64)) dut (
    .rx_clk           (clk),
    .reset            (reset),
    .rx_dv            (rx_dv),
    .rxd              (rxd),
    .rx_er            (rx_er),
    .timestamp        (timestamp),
    .data_almost_full (data_almost_full),
    .meta_full        (meta_full),
    .log_en           (log_en),
    .log_d            (log_d),
    .log_frame_end    (log_frame_end),
    .meta_en          (meta_en),
    .meta_d           (meta_d),
    .frame_count      (frame_count),
    .drop_count       (drop_count)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  got_q[$];
  int          end_pos_q[$];
  int          end_cyc_q[$];
  logic [63:0] meta_q[$];
  int          meta_cyc_q[$];

  always @(negedge clk) begin
    if (log_en) begin
      got_q.push_back(log_d);
      if (log_frame_end) begin
        end_pos_q.push_back(got_q.size());
        end_cyc_q.push_back(cyc);
      end
    end
    if (meta_en) begin
      meta_q.push_back(meta_d);
      meta_cyc_q.push_back(cyc);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] tx[$];
  int         last_cyc;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic build_frame(input int n, input int seed, input bit flip);
    logic [31:0] c;
    logic [31:0] fcs;
    logic [7:0]  b;
    tx.delete();
    c = 32'hFFFFFFFF;
    if (n >= 4) begin
      for (int i = 0; i < n - 4; i++) begin
        b = 8'((i * 13 + seed) & 255);
        tx.push_back(b);
        c = crc_upd(c, b);
      end
      fcs = ~c;
      tx.push_back(fcs[7:0]);
      tx.push_back(fcs[15:8]);
      tx.push_back(fcs[23:16]);
      tx.push_back(fcs[31:24]);
      if (flip) tx[7] = tx[7] ^ 8'h10;
    end
  endtask

  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    @(negedge clk);
    rx_dv = dv;
    rxd   = d;
    rx_er = er;
  endtask

  task automatic send_frame(input int er_idx, input int gap);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    last_cyc = cyc;
    for (int i = 0; i < tx.size(); i++) begin
      drive(1'b1, tx[i], i == er_idx);
      last_cyc = cyc;
    end
    for (int i = 0; i < gap; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic frame_checks(input string tag, input int g0, input int e0, input int m0,
                              input int nlog, input logic [63:0] exp_meta, input int lastc,
                              input bit end_timing, input int fc);
    check_eq({tag, " log_count"}, 64'(got_q.size() - g0), 64'(nlog));
    for (int i = 0; i < nlog; i++) begin
      if (g0 + i < got_q.size()) check_eq({tag, " byte"}, 64'(got_q[g0+i]), 64'(tx[i]));
    end
    if (nlog > 0) begin
      check_eq({tag, " end_count"}, 64'(end_pos_q.size() - e0), 64'd1);
      if (end_pos_q.size() > e0) begin
        check_eq({tag, " end_pos"}, 64'(end_pos_q[e0]), 64'(g0 + nlog));
        if (end_timing) check_eq({tag, " end_cycle"}, 64'(end_cyc_q[e0]), 64'(lastc + 2));
      end
    end else begin
      check_eq({tag, " end_count"}, 64'(end_pos_q.size() - e0), 64'd0);
    end
    check_eq({tag, " meta_count"}, 64'(meta_q.size() - m0), 64'd1);
    if (meta_q.size() > m0) begin
      check_eq({tag, " meta_d"}, meta_q[m0], exp_meta);
      check_eq({tag, " meta_cycle"}, 64'(meta_cyc_q[m0]), 64'(lastc + 3));
    end
    check_eq({tag, " frame_count"}, 64'(frame_count), 64'(fc));
  endtask

  int g0, e0, m0, lc0;

  task automatic snap();
    g0 = got_q.size();
    e0 = end_pos_q.size();
    m0 = meta_q.size();
  endtask

  initial begin
    reset = 1'b1;
    rx_dv = 1'b0;
    rxd = 8'h00;
    rx_er = 1'b0;
    timestamp = 32'h0;
    data_almost_full = 1'b0;
    meta_full = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst log_en", 64'(log_en), 64'd0);
    check_eq("rst meta_en", 64'(meta_en), 64'd0);
    check_eq("rst meta_d", meta_d, 64'd0);
    check_eq("rst frame_count", 64'(frame_count), 64'd0);
    check_eq("rst drop_count", 64'(drop_count), 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    build_frame(64, 1, 1'b0);
    timestamp = 32'h12345678;
    snap();
    send_frame(-1, 8);
    frame_checks("good64", g0, e0, m0, 64, 64'h12345678_0001_0040, last_cyc, 1'b1, 1);

    build_frame(64, 2, 1'b1);
    timestamp = 32'h0000AAAA;
    snap();
    send_frame(-1, 8);
    frame_checks("badfcs", g0, e0, m0, 64, 64'h0000AAAA_0000_0040, last_cyc, 1'b1, 2);

    build_frame(60, 3, 1'b0);
    timestamp = 32'h00000003;
    snap();
    send_frame(10, 8);
    frame_checks("rxer60", g0, e0, m0, 60, 64'h00000003_000B_003C, last_cyc, 1'b1, 3);

    build_frame(100, 4, 1'b0);
    data_almost_full = 1'b1;
    snap();
    send_frame(-1, 8);
    data_almost_full = 1'b0;
    check_eq("drop log_count", 64'(got_q.size() - g0), 64'd0);
    check_eq("drop meta_count", 64'(meta_q.size() - m0), 64'd0);
    check_eq("drop drop_count", 64'(drop_count), 64'd1);
    check_eq("drop frame_count", 64'(frame_count), 64'd3);

    build_frame(64, 5, 1'b0);
    timestamp = 32'h00000005;
    snap();
    send_frame(-1, 8);
    frame_checks("after_drop", g0, e0, m0, 64, 64'h00000005_0001_0040, last_cyc, 1'b1, 4);

    meta_full = 1'b1;
    snap();
    send_frame(-1, 8);
    meta_full = 1'b0;
    check_eq("mfull log_count", 64'(got_q.size() - g0), 64'd0);
    check_eq("mfull meta_count", 64'(meta_q.size() - m0), 64'd0);
    check_eq("mfull drop_count", 64'(drop_count), 64'd2);

    build_frame(200, 6, 1'b0);
    timestamp = 32'h00000006;
    snap();
    send_frame(-1, 8);
    frame_checks("trunc200", g0, e0, m0, 128, 64'h00000006_0005_00C8, last_cyc, 1'b0, 5);

    build_frame(0, 0, 1'b0);
    timestamp = 32'h00000007;
    snap();
    send_frame(-1, 8);
    frame_checks("zero_len", g0, e0, m0, 0, 64'h00000007_0008_0000, last_cyc, 1'b1, 6);

    build_frame(64, 8, 1'b0);
    timestamp = 32'h000000A1;
    snap();
    send_frame(-1, 1);
    lc0 = last_cyc;
    timestamp = 32'h000000B2;
    send_frame(-1, 8);
    check_eq("b2b log_count", 64'(got_q.size() - g0), 64'd128);
    check_eq("b2b meta_count", 64'(meta_q.size() - m0), 64'd2);
    if (meta_q.size() >= m0 + 2) begin
      check_eq("b2b meta_a", meta_q[m0], 64'h000000A1_0001_0040);
      check_eq("b2b meta_a_cycle", 64'(meta_cyc_q[m0]), 64'(lc0 + 3));
      check_eq("b2b meta_b", meta_q[m0+1], 64'h000000B2_0001_0040);
    end
    check_eq("b2b frame_count", 64'(frame_count), 64'd8);

    build_frame(64, 9, 1'b0);
    timestamp = 32'h000000C3;
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, tx[i], 1'b0);
    @(negedge clk);
    reset = 1'b1;
    rxd = tx[20];
    drive(1'b1, tx[21], 1'b0);
    check_eq("midrst log_en", 64'(log_en), 64'd0);
    check_eq("midrst frame_count", 64'(frame_count), 64'd0);
    check_eq("midrst drop_count", 64'(drop_count), 64'd0);
    snap();
    @(negedge clk);
    reset = 1'b0;
    rxd = tx[22];
    for (int i = 23; i < 64; i++) drive(1'b1, tx[i], 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b0, 8'h00, 1'b0);
    check_eq("midrst quiet log", 64'(got_q.size() - g0), 64'd0);
    check_eq("midrst quiet meta", 64'(meta_q.size() - m0), 64'd0);

    build_frame(64, 10, 1'b0);
    timestamp = 32'h000000D4;
    snap();
    send_frame(-1, 8);
    frame_checks("post_rst", g0, e0, m0, 64, 64'h000000D4_0001_0040, last_cyc, 1'b1, 1);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
